// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the multiplier subsystem: default widths and block
// size, plus the accumulator control state encoding.
// Pure declarations; no logic.
package product_accumulator_pkg;

    localparam int DEF_M     = 4;
    localparam int DEF_N     = 4;
    localparam int DEF_ACC_W = 12;
    localparam int DEF_COUNT = 4;

    // ACC: taking products into the running sum; HOLD: block sum pending
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/acc_adder.sv
// Accumulator adder: acc + zero-extended product, with carry-out of the top bit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module acc_adder #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [IN_W-1:0]  prod_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] full;

    // One extra bit captures the wrap so the caller can keep a sticky overflow
    always_comb begin
        full    = {1'b0, acc_i} + {{(ACC_W + 1 - IN_W){1'b0}}, prod_i};
        sum_o   = full[ACC_W-1:0];
        carry_o = full[ACC_W];
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of COUNT unsigned products and presents each block sum with a sticky overflow flag.
// Latency: sum_valid rises the cycle after the COUNT-th accepted product.
// Backpressure: prod_ready drops while a sum is pending; one bubble cycle after each sum accept.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int N     = DEF_N,
    parameter int ACC_W = DEF_ACC_W,
    parameter int COUNT = DEF_COUNT,
    localparam int P_W   = M + N,
    localparam int CNT_W = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [P_W-1:0]   prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sum_ovf,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sum_ovf_q, sum_ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             accept;

    acc_adder #(
        .IN_W  (P_W),
        .ACC_W (ACC_W)
    ) u_adder (
        .acc_i   (acc_q),
        .prod_i  (prod),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    assign prod_ready = (state_q == ACC);
    assign sum_valid  = (state_q == HOLD);
    assign sum        = sum_q;
    assign sum_ovf    = sum_ovf_q;
    assign cnt        = cnt_q;
    assign accept     = prod_valid & prod_ready;

    // Next-state: accumulate on accept, close the block on the last product, release on sum_ready
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        sum_ovf_d = sum_ovf_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    if (cnt_q == LAST) begin
                        sum_d     = add_sum;
                        sum_ovf_d = ovf_q | add_carry;
                        acc_d     = '0;
                        ovf_d     = 1'b0;
                        cnt_d     = '0;
                        state_d   = HOLD;
                    end else begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_carry;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // No product is taken in this cycle, which gives the one-cycle bubble
                if (sum_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // State registers; reset and clr both wipe the block and any pending sum
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q   <= ACC;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            sum_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (ACC_W=12/COUNT=4, ACC_W=9/COUNT=4,
// ACC_W=12/COUNT=1) share one stimulus stream; a block-level model checks all of them
// every cycle, and directed table/sequences pin the documented corner cases.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] prod = '0;
    logic       prod_valid = 1'b0;
    logic       sum_ready = 1'b0;

    logic        pr_12, sv_12, ovf_12;
    logic [11:0] sum_12;
    logic [2:0]  cnt_12;
    logic        pr_9, sv_9, ovf_9;
    logic [8:0]  sum_9;
    logic [2:0]  cnt_9;
    logic        pr_1, sv_1, ovf_1;
    logic [11:0] sum_1;
    logic [0:0]  cnt_1;

    int ntests = 0;
    int nfail  = 0;
    bit model_on = 0;

    always #5 clk = ~clk;

    product_accumulator #(.M(4), .N(4), .ACC_W(12), .COUNT(4)) u12 (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(pr_12), .sum(sum_12), .sum_ovf(ovf_12), .sum_valid(sv_12),
        .sum_ready(sum_ready), .cnt(cnt_12));

    product_accumulator #(.M(4), .N(4), .ACC_W(9), .COUNT(4)) u9 (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(pr_9), .sum(sum_9), .sum_ovf(ovf_9), .sum_valid(sv_9),
        .sum_ready(sum_ready), .cnt(cnt_9));

    product_accumulator #(.M(4), .N(4), .ACC_W(12), .COUNT(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(pr_1), .sum(sum_1), .sum_ovf(ovf_1), .sum_valid(sv_1),
        .sum_ready(sum_ready), .cnt(cnt_1));

    // Per-instance view for the model checker
    logic        a_pr [3];
    logic        a_sv [3];
    logic        a_ovf[3];
    logic [31:0] a_sum[3];
    logic [31:0] a_cnt[3];
    assign a_pr[0] = pr_12;  assign a_pr[1] = pr_9;  assign a_pr[2] = pr_1;
    assign a_sv[0] = sv_12;  assign a_sv[1] = sv_9;  assign a_sv[2] = sv_1;
    assign a_ovf[0] = ovf_12; assign a_ovf[1] = ovf_9; assign a_ovf[2] = ovf_1;
    assign a_sum[0] = 32'(sum_12); assign a_sum[1] = 32'(sum_9); assign a_sum[2] = 32'(sum_1);
    assign a_cnt[0] = 32'(cnt_12); assign a_cnt[1] = 32'(cnt_9); assign a_cnt[2] = 32'(cnt_1);

    // Block-level reference: exact (unbounded) running sum per block, a pending flag,
    // and the exact total of the pending block. Wrap and overflow are derived at check time.
    int     w_a[3] = '{12, 9, 12};
    int     c_a[3] = '{4, 4, 1};
    longint m_acc [3];
    int     m_n   [3];
    bit     m_pend[3];
    longint m_psum[3];

    task automatic chk(input string nm, input longint act, input longint exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst || clr) begin
                m_acc[k] = 0; m_n[k] = 0; m_pend[k] = 0; m_psum[k] = 0;
            end else if (m_pend[k]) begin
                if (sum_ready) m_pend[k] = 0;
            end else if (prod_valid) begin
                m_acc[k] += longint'(prod);
                m_n[k]++;
                if (m_n[k] == c_a[k]) begin
                    m_pend[k] = 1;
                    m_psum[k] = m_acc[k];
                    m_acc[k]  = 0;
                    m_n[k]    = 0;
                end
            end
        end
    endtask

    task automatic model_check();
        longint modv;
        for (int k = 0; k < 3; k++) begin
            modv = longint'(1) << w_a[k];
            chk($sformatf("model[%0d].prod_ready", k), longint'(a_pr[k]), longint'(!m_pend[k]));
            chk($sformatf("model[%0d].sum_valid", k), longint'(a_sv[k]), longint'(m_pend[k]));
            chk($sformatf("model[%0d].cnt", k), longint'(a_cnt[k]), longint'(m_n[k]));
            if (m_pend[k]) begin
                chk($sformatf("model[%0d].sum", k), longint'(a_sum[k]), m_psum[k] % modv);
                chk($sformatf("model[%0d].sum_ovf", k), longint'(a_ovf[k]),
                    longint'(m_psum[k] >= modv));
            end
        end
    endtask

    // One clock: model advances on the edge with the inputs the DUT saw, outputs sampled 1 unit later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (model_on) model_check();
    endtask

    task automatic drive(input logic v, input logic [7:0] p, input logic sr);
        prod_valid = v;
        prod       = p;
        sum_ready  = sr;
    endtask

    typedef struct {
        logic       pv;
        logic [7:0] p;
        logic       sr;
        logic       e_pr;
        logic       e_sv;
        int         e_cnt;
        int         e_sum;
        int         e_sum9;
        logic       e_ovf9;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic pv, logic [7:0] p, logic sr, logic e_pr, logic e_sv,
                                int e_cnt, int e_sum, int e_sum9, logic e_ovf9);
        vec_t v;
        v.pv = pv; v.p = p; v.sr = sr; v.e_pr = e_pr; v.e_sv = e_sv;
        v.e_cnt = e_cnt; v.e_sum = e_sum; v.e_sum9 = e_sum9; v.e_ovf9 = e_ovf9;
        return v;
    endfunction

    initial begin
        // 4 x 225 back to back, then sum accept
        tbl.push_back(mk(1, 225, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 225, 1, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 225, 1, 1, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 225, 1, 0, 1, 0, 900, 388, 1));
        tbl.push_back(mk(0, 0,   1, 1, 0, 0, 0, 0, 0));
        // 9, 0, 24, 255 with two idle cycles between products
        tbl.push_back(mk(1, 9,   1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,   1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,   1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0,   1, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0,   1, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0,   1, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 24,  1, 1, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0,   1, 1, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0,   1, 1, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 255, 1, 0, 1, 0, 288, 288, 0));
        tbl.push_back(mk(0, 0,   1, 1, 0, 0, 0, 0, 0));

        // Reset
        rst = 1'b1;
        drive(1, 8'd77, 0);
        tick();
        rst = 1'b0;
        drive(0, 8'd0, 0);
        model_on = 1;
        chk("reset.sum", longint'(sum_12), 0);
        chk("reset.sum_ovf", longint'(ovf_12), 0);
        chk("reset.sum_valid", longint'(sv_12), 0);
        chk("reset.prod_ready", longint'(pr_12), 1);
        chk("reset.cnt", longint'(cnt_12), 0);

        // Table-driven directed vectors
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pv, tbl[i].p, tbl[i].sr);
            tick();
            chk($sformatf("tbl[%0d].prod_ready", i), longint'(pr_12), longint'(tbl[i].e_pr));
            chk($sformatf("tbl[%0d].sum_valid", i), longint'(sv_12), longint'(tbl[i].e_sv));
            chk($sformatf("tbl[%0d].cnt", i), longint'(cnt_12), longint'(tbl[i].e_cnt));
            if (tbl[i].e_sv) begin
                chk($sformatf("tbl[%0d].sum", i), longint'(sum_12), longint'(tbl[i].e_sum));
                chk($sformatf("tbl[%0d].sum_ovf", i), longint'(ovf_12), 0);
                chk($sformatf("tbl[%0d].sum9", i), longint'(sum_9), longint'(tbl[i].e_sum9));
                chk($sformatf("tbl[%0d].ovf9", i), longint'(ovf_9), longint'(tbl[i].e_ovf9));
            end
        end

        // Backpressure: sum held for 5 cycles with a product waiting
        clr = 1'b1; drive(0, 0, 0); tick(); clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'd5, 0);
            tick();
        end
        chk("bp.sum_valid", longint'(sv_12), 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'd5, 0);
            tick();
            chk("bp.prod_ready_low", longint'(pr_12), 0);
            chk("bp.sum_stable", longint'(sum_12), 20);
        end
        drive(1, 8'd5, 1);
        tick();
        chk("bp.release_sv", longint'(sv_12), 0);
        chk("bp.release_pr", longint'(pr_12), 1);
        chk("bp.release_cnt", longint'(cnt_12), 0);
        drive(1, 8'd5, 0);
        tick();
        chk("bp.held_accept_cnt", longint'(cnt_12), 1);

        // clr mid-block, then a clean block of ones, then clr while holding
        drive(0, 0, 0); clr = 1'b1; tick(); clr = 1'b0;
        chk("clr.cnt0", longint'(cnt_12), 0);
        drive(1, 8'd9, 0); tick(); tick();
        chk("clr.cnt2", longint'(cnt_12), 2);
        drive(0, 0, 0); clr = 1'b1; tick(); clr = 1'b0;
        chk("clr.cnt_cleared", longint'(cnt_12), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'd1, 0);
            tick();
        end
        chk("clr.sum_valid", longint'(sv_12), 1);
        chk("clr.sum", longint'(sum_12), 4);
        chk("clr.sum9", longint'(sum_9), 4);
        chk("clr.ovf9_cleared", longint'(ovf_9), 0);
        drive(0, 0, 0); clr = 1'b1; tick(); clr = 1'b0;
        chk("clr.hold_drop", longint'(sv_12), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1);
            tick();
            chk("clr.no_sum", longint'(sv_12), 0);
        end

        // Reset mid-block with a product offered
        drive(1, 8'd3, 0); tick(); tick();
        chk("rst.cnt_before", longint'(cnt_12), 2);
        rst = 1'b1; drive(1, 8'd3, 0); tick(); rst = 1'b0;
        chk("rst.cnt", longint'(cnt_12), 0);
        chk("rst.sum_valid", longint'(sv_12), 0);
        chk("rst.prod_ready", longint'(pr_12), 1);
        drive(0, 0, 0); tick();
        chk("rst.cnt_after", longint'(cnt_12), 0);

        // Randomised traffic, checked by the model inside tick()
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
